uart_transceiver_core: RTL and testbench

//  Full-duplex 8N1 UART: serialises a byte on tx, deserialises bytes from rx.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx.sv | 117 +++++++++++
 rtl/uart_transceiver_core.sv | 118 +++++++++++
 tb/tb_uart_transceiver_core.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the 8N1 UART transceiver (uart_transceiver_core, uart_rx).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  function automatic int clks_per_bit(input int clk, input int baud);
    return clk / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchroniser, mid-bit sampler and RX FSM.
// Optional rx_frame_err output when UART_FRAME_ERR_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CPB = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid
`ifdef UART_FRAME_ERR_EN
  ,
  output logic       rx_frame_err
`endif
);

  localparam int CW = $clog2(CPB + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);

  uart_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shreg_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          ferr_q;
  logic          wait_hi_q;
  logic          rx_meta_q;
  logic          rx_sync_q;

  // Synchroniser, receive FSM and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      shreg_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      wait_hi_q <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_sync_q) begin
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          // A start bit that is high again at its midpoint was a glitch
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            bit_q <= 3'd0;
            state_q <= rx_sync_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shreg_q <= {rx_sync_q, shreg_q[7:1]};
            if (bit_q == 3'(DATA_BITS - 1)) begin
              bit_q   <= 3'd0;
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          // After a framing error, hold off until the line returns high
          if (wait_hi_q) begin
            if (rx_sync_q) begin
              wait_hi_q <= 1'b0;
              state_q   <= IDLE;
            end
          end else if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rx_sync_q) begin
              data_q  <= shreg_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              ferr_q    <= 1'b1;
              wait_hi_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rx_data  = data_q;
  assign rx_valid = valid_q;
`ifdef UART_FRAME_ERR_EN
  assign rx_frame_err = ferr_q;
`endif

endmodule

// File: rtl/uart_transceiver_core.sv
// Full-duplex 8N1 UART: inline TX FSM plus uart_rx receiver on a shared clock.
// Define UART_FRAME_ERR_EN to expose the rx_frame_err pulse output.
module uart_transceiver_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid
`ifdef UART_FRAME_ERR_EN
  ,
  output logic       rx_frame_err
`endif
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CW  = $clog2(CPB + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CPB - 1);

  uart_state_e   tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shreg_q;
  logic          tx_q;
  logic          tx_busy_q;

  // Transmit FSM with registered line and busy outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_shreg_q <= 8'h00;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      case (tx_state_q)
        IDLE: begin
          if (tx_start) begin
            tx_shreg_q <= tx_data;
            tx_cnt_q   <= '0;
            tx_q       <= 1'b0;
            tx_busy_q  <= 1'b1;
            tx_state_q <= START;
          end
        end
        START: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_q       <= tx_shreg_q[0];
            tx_state_q <= DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'(DATA_BITS - 1)) begin
              tx_bit_q   <= 3'd0;
              tx_q       <= 1'b1;
              tx_state_q <= STOP;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shreg_q <= {1'b0, tx_shreg_q[7:1]};
              tx_q       <= tx_shreg_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'(STOP_BITS - 1)) begin
              tx_busy_q  <= 1'b0;
              tx_state_q <= IDLE;
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        default: begin
          tx_state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx      = tx_q;
  assign tx_busy = tx_busy_q;

  uart_rx #(
    .CPB(CPB)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid)
`ifdef UART_FRAME_ERR_EN
    ,
    .rx_frame_err(rx_frame_err)
`endif
  );

endmodule

// File: tb/tb_uart_transceiver_core.sv
// Scoreboard bench for uart_transceiver_core: tx looped to rx, with a bench-driven rx override.
module tb_uart_transceiver_core;

  localparam int CPB = 50000000 / 115200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx;
  logic       tx_busy;
  logic       rx_line;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       use_tb_rx = 1'b0;
  logic       tb_rx = 1'b1;
`ifdef UART_FRAME_ERR_EN
  logic       rx_frame_err;
  int         ferr_cnt = 0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int last_valid_cyc = 0;
  logic prev_valid = 1'b0;
  logic [7:0] sb_q[$];

  assign rx_line = use_tb_rx ? tb_rx : tx;

  uart_transceiver_core dut (
    .clk         (clk),
    .rst         (rst),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .rx          (rx_line),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid)
`ifdef UART_FRAME_ERR_EN
    ,
    .rx_frame_err(rx_frame_err)
`endif
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Receive-side monitor: every rx_valid pulse is matched against the scoreboard
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      check_eq("rx_pulse_width", {31'd0, prev_valid}, 32'd0);
      if (sb_q.size() == 0) check_eq("rx_unexpected", {31'd0, rx_valid}, 32'd0);
      else check_eq("rx_data", {24'd0, rx_data}, {24'd0, sb_q.pop_front()});
    end
`ifdef UART_FRAME_ERR_EN
    if (rx_frame_err) ferr_cnt++;
`endif
    prev_valid = rx_valid;
  end

  task automatic send_byte(input logic [7:0] b, input bit expect_rx);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    if (expect_rx) sb_q.push_back(b);
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb_q.size() != 0 && n < 12000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, sb_q.size(), 32'd0);
    sb_q.delete();
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tb_rx = frame[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk);
    tb_rx = 1'b1;
  endtask

  initial begin
    int t0;
    int n;
    int v0;
`ifdef UART_FRAME_ERR_EN
    int f0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_tx", {31'd0, tx}, 32'd1);
    check_eq("rst_busy", {31'd0, tx_busy}, 32'd0);
    check_eq("rst_rx_data", {24'd0, rx_data}, 32'h00);
    check_eq("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: single byte, busy length and loopback latency
    t0 = cyc;
    send_byte(8'hA5, 1'b1);
    n = 1;
    while (tx_busy && n < 6000) begin
      @(negedge clk);
      if (tx_busy) n++;
    end
    check_eq("busy_len", n, 32'd4340);
    drain("drain_a5");
    check_eq("latency_in_range",
             {31'd0, (last_valid_cyc - t0 >= 4126) && (last_valid_cyc - t0 <= 4128)}, 32'd1);

    // 2: back-to-back 00 then FF
    send_byte(8'h00, 1'b1);
    n = 0;
    while (tx_busy && n < 6000) begin
      @(negedge clk);
      n++;
    end
    tx_data  = 8'hFF;
    tx_start = 1'b1;
    sb_q.push_back(8'hFF);
    @(negedge clk);
    tx_start = 1'b0;
    check_eq("b2b_accept", {31'd0, tx_busy}, 32'd1);
    drain("drain_00_ff");

    // 3: tx_start during a frame is ignored
    repeat (CPB) @(negedge clk);
    send_byte(8'h5A, 1'b1);
    repeat (1000) @(negedge clk);
    send_byte(8'h3C, 1'b0);
    tx_data = 8'h11;
    drain("drain_5a");
    repeat (CPB * 12) @(negedge clk);
    check_eq("ignored_idle", {31'd0, tx_busy}, 32'd0);

    // 4: short glitch on rx, then a good injected frame
    use_tb_rx = 1'b1;
    v0 = valid_cnt;
    @(negedge clk);
    tb_rx = 1'b0;
    repeat (100) @(negedge clk);
    tb_rx = 1'b1;
    repeat (1000) @(negedge clk);
    check_eq("glitch_no_valid", valid_cnt - v0, 32'd0);
    sb_q.push_back(8'h96);
    rx_frame(8'h96, 1'b1);
    drain("drain_96");
    use_tb_rx = 1'b0;
    repeat (CPB) @(negedge clk);

    // 5: reset during DATA bits of C3
    v0 = valid_cnt;
    send_byte(8'hC3, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_tx", {31'd0, tx}, 32'd1);
    check_eq("abort_busy", {31'd0, tx_busy}, 32'd0);
    check_eq("abort_rx_data", {24'd0, rx_data}, 32'h00);
    repeat (5000) @(negedge clk);
    check_eq("abort_no_valid", valid_cnt - v0, 32'd0);
    send_byte(8'h81, 1'b1);
    drain("drain_81");

    // 6: framing error, then re-arm with a good frame
    use_tb_rx = 1'b1;
    v0 = valid_cnt;
`ifdef UART_FRAME_ERR_EN
    f0 = ferr_cnt;
`endif
    rx_frame(8'h55, 1'b0);
    repeat (CPB) @(negedge clk);
    check_eq("ferr_no_valid", valid_cnt - v0, 32'd0);
    check_eq("ferr_rx_data_kept", {24'd0, rx_data}, 32'h81);
`ifdef UART_FRAME_ERR_EN
    check_eq("ferr_pulse", ferr_cnt - f0, 32'd1);
`endif
    sb_q.push_back(8'hE7);
    rx_frame(8'hE7, 1'b1);
    drain("drain_e7");
    use_tb_rx = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
